// File: rtl/syn_pkg.sv
// syn_pkg: shared constants, parser/bit-layer state encodings and checksum helper for the time-sync receiver
package syn_pkg;
    localparam logic [7:0]  HDR0       = 8'hAA;
    localparam logic [7:0]  HDR1       = 8'h55;
    localparam logic [31:0] NS_PER_SEC = 32'd1_000_000_000;

    localparam logic [1:0] ST_HUNT1 = 2'd0;
    localparam logic [1:0] ST_HUNT2 = 2'd1;
    localparam logic [1:0] ST_SEC   = 2'd2;
    localparam logic [1:0] ST_CHK   = 2'd3;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    function automatic logic [7:0] xor4(input logic [31:0] s);
        return s[31:24] ^ s[23:16] ^ s[15:8] ^ s[7:0];
    endfunction
endpackage

// File: rtl/syn_uart_rx.sv
// syn_uart_rx: 8N1 LSB-first receiver with input synchroniser, mid-bit sampling and stop-bit framing check
module syn_uart_rx
    import syn_pkg::*;
#(
    parameter int unsigned TBIT_CLKS = 1000
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_vld,
    output logic       frm_err
);
    localparam int CW = $clog2(TBIT_CLKS + 1);
    localparam logic [CW-1:0] HALF = CW'(TBIT_CLKS / 2);
    localparam logic [CW-1:0] FULL = CW'(TBIT_CLKS - 1);

    logic [2:0]    sync_q, sync_d;
    logic [1:0]    st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          vld_q, vld_d, err_q, err_d;
    logic          rx_s, rx_p;

    assign rx_s     = sync_q[1];
    assign rx_p     = sync_q[2];
    assign rx_byte  = sh_q;
    assign byte_vld = vld_q;
    assign frm_err  = err_q;

    // Bit timer: edge-start, half-bit start recheck, then one sample per bit period
    always_comb begin
        sync_d = {sync_q[1:0], rx};
        st_d   = st_q;
        cnt_d  = cnt_q + CW'(1);
        bit_d  = bit_q;
        sh_d   = sh_q;
        vld_d  = 1'b0;
        err_d  = 1'b0;
        case (st_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (rx_p && !rx_s) st_d = RX_START;
            end
            RX_START: if (cnt_q == HALF) begin
                cnt_d = '0;
                bit_d = '0;
                st_d  = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (cnt_q == FULL) begin
                cnt_d = '0;
                sh_d  = {rx_s, sh_q[7:1]};
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) st_d = RX_STOP;
            end
            default: if (cnt_q == FULL) begin
                st_d  = RX_IDLE;
                vld_d = rx_s;
                err_d = !rx_s;
            end
        endcase
    end

    // State registers; synchroniser resets to idle-high so reset release is not seen as a start edge
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b111;
            st_q   <= RX_IDLE;
            cnt_q  <= '0;
            bit_q  <= '0;
            sh_q   <= '0;
            vld_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            bit_q  <= bit_d;
            sh_q   <= sh_d;
            vld_q  <= vld_d;
            err_q  <= err_d;
        end
    end
endmodule

// File: rtl/syn_time_rx.sv
// syn_time_rx: sync-frame parser, local UTC/ns clock with frame load, holdover lock status and error counter
module syn_time_rx
    import syn_pkg::*;
#(
    parameter int unsigned TBIT_CLKS  = 1000,
    parameter int unsigned NS_PER_CLK = 10,
    parameter int unsigned LAT_NS     = 0,
    parameter int unsigned HOLD_SEC   = 4
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        rx_syn,
    output logic [31:0] utc_sec,
    output logic [31:0] now_ns,
    output logic        locked,
    output logic        frame_ok,
    output logic [7:0]  err_cnt
);
    localparam logic [31:0] GAP_CLKS = 32'(20 * TBIT_CLKS);

    logic [7:0]  rx_byte;
    logic        byte_vld, frm_err;
    logic [1:0]  st_q, st_d, idx_q, idx_d;
    logic [31:0] sec_q, sec_d, gap_q, gap_d, hold_q, hold_d;
    logic [31:0] utc_sec_q, utc_sec_d, now_ns_q, now_ns_d;
    logic        locked_q, locked_d, frame_ok_q, frame_ok_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        in_chk, acc, ck_err, timeout, roll;
    logic [32:0] sum;

    syn_uart_rx #(.TBIT_CLKS(TBIT_CLKS)) u_rx (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .rx       (rx_syn),
        .rx_byte  (rx_byte),
        .byte_vld (byte_vld),
        .frm_err  (frm_err)
    );

    assign utc_sec  = utc_sec_q;
    assign now_ns   = now_ns_q;
    assign locked   = locked_q;
    assign frame_ok = frame_ok_q;
    assign err_cnt  = err_cnt_q;

    // Frame parser with header resync and inter-byte gap watchdog
    always_comb begin
        in_chk  = byte_vld && st_q == ST_CHK;
        acc     = in_chk && rx_byte == xor4(sec_q);
        ck_err  = in_chk && rx_byte != xor4(sec_q);
        timeout = !byte_vld && st_q != ST_HUNT1 && gap_q >= GAP_CLKS - 32'd1;
        gap_d   = (byte_vld || st_q == ST_HUNT1) ? '0 : gap_q + 32'd1;
        st_d    = timeout ? ST_HUNT1 : st_q;
        sec_d   = sec_q;
        idx_d   = idx_q;
        if (byte_vld) begin
            case (st_q)
                ST_HUNT1: st_d = rx_byte == HDR0 ? ST_HUNT2 : ST_HUNT1;
                ST_HUNT2: begin
                    idx_d = '0;
                    st_d  = rx_byte == HDR1 ? ST_SEC : rx_byte == HDR0 ? ST_HUNT2 : ST_HUNT1;
                end
                ST_SEC: begin
                    sec_d = {sec_q[23:0], rx_byte};
                    idx_d = idx_q + 2'd1;
                    st_d  = idx_q == 2'd3 ? ST_CHK : ST_SEC;
                end
                default: st_d = ST_HUNT1;
            endcase
        end
    end

    // Time counter, holdover tracking and error counter; a frame load overrides the free-run step
    always_comb begin
        sum        = {1'b0, now_ns_q} + 33'(NS_PER_CLK);
        roll       = sum >= {1'b0, NS_PER_SEC};
        now_ns_d   = acc ? 32'(LAT_NS) : roll ? 32'(sum - {1'b0, NS_PER_SEC}) : sum[31:0];
        utc_sec_d  = acc ? sec_q : utc_sec_q + {31'd0, roll};
        hold_d     = acc ? '0 : (roll && hold_q < 32'(HOLD_SEC)) ? hold_q + 32'd1 : hold_q;
        locked_d   = acc ? 1'b1 : (roll && hold_d >= 32'(HOLD_SEC)) ? 1'b0 : locked_q;
        frame_ok_d = acc;
        err_cnt_d  = ((frm_err || ck_err || timeout) && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    // All state registers
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= ST_HUNT1;
            idx_q      <= '0;
            sec_q      <= '0;
            gap_q      <= '0;
            hold_q     <= '0;
            utc_sec_q  <= '0;
            now_ns_q   <= '0;
            locked_q   <= 1'b0;
            frame_ok_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            st_q       <= st_d;
            idx_q      <= idx_d;
            sec_q      <= sec_d;
            gap_q      <= gap_d;
            hold_q     <= hold_d;
            utc_sec_q  <= utc_sec_d;
            now_ns_q   <= now_ns_d;
            locked_q   <= locked_d;
            frame_ok_q <= frame_ok_d;
            err_cnt_q  <= err_cnt_d;
        end
    end
endmodule

// File: tb/tb_syn_time_rx.sv
// tb_syn_time_rx: scoreboard bench over three parameterisations of syn_time_rx
module tb_syn_time_rx;
    localparam int TB = 10;

    typedef struct packed {
        logic [1:0]  dut;
        logic [31:0] sec;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx [3];
    logic [31:0] utc [3];
    logic [31:0] now [3];
    logic        locked [3];
    logic        fok [3];
    logic [7:0]  err [3];

    int unsigned lat  [3] = '{0, 999_999_950, 0};
    int unsigned nspc [3] = '{10, 10, 100_000_000};

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          ok_cnt [3] = '{0, 0, 0};
    int          ok_cyc [3] = '{0, 0, 0};
    logic [31:0] last_sec [3];

    syn_time_rx #(.TBIT_CLKS(TB), .NS_PER_CLK(10), .LAT_NS(0), .HOLD_SEC(4)) dut_a (
        .clk_sys(clk), .rst_n(rst_n), .rx_syn(rx[0]), .utc_sec(utc[0]), .now_ns(now[0]),
        .locked(locked[0]), .frame_ok(fok[0]), .err_cnt(err[0]));
    syn_time_rx #(.TBIT_CLKS(TB), .NS_PER_CLK(10), .LAT_NS(999_999_950), .HOLD_SEC(4)) dut_b (
        .clk_sys(clk), .rst_n(rst_n), .rx_syn(rx[1]), .utc_sec(utc[1]), .now_ns(now[1]),
        .locked(locked[1]), .frame_ok(fok[1]), .err_cnt(err[1]));
    syn_time_rx #(.TBIT_CLKS(TB), .NS_PER_CLK(100_000_000), .LAT_NS(0), .HOLD_SEC(2)) dut_c (
        .clk_sys(clk), .rst_n(rst_n), .rx_syn(rx[2]), .utc_sec(utc[2]), .now_ns(now[2]),
        .locked(locked[2]), .frame_ok(fok[2]), .err_cnt(err[2]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every frame_ok pulse must match the oldest expected frame
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_n && fok[i]) begin
                n_tests++;
                if (exp_q.size() == 0 || exp_q[0].dut != 2'(i)) begin
                    n_fail++;
                    $display("FAIL frame_ok_unexpected dut%0d: got pulse utc=%h, expected no pulse", i, utc[i]);
                end else begin
                    mon_e = exp_q.pop_front();
                    last_sec[i] = mon_e.sec;
                    if (utc[i] !== mon_e.sec || now[i] !== lat[i] || locked[i] !== 1'b1) begin
                        n_fail++;
                        $display("FAIL frame_load dut%0d: got utc=%h ns=%0d lock=%b, expected utc=%h ns=%0d lock=1",
                                 i, utc[i], now[i], locked[i], mon_e.sec, lat[i]);
                    end
                end
                ok_cyc[i] = cyc;
                ok_cnt[i]++;
            end
        end
        if (rst_n && ok_cnt[1] > 0 && cyc == ok_cyc[1] + 4) begin
            n_tests++;
            if (utc[1] !== 32'hFFFF_FFFF || now[1] !== 32'd999_999_990) begin
                n_fail++;
                $display("FAIL pre_wrap: got utc=%h ns=%0d, expected utc=ffffffff ns=999999990", utc[1], now[1]);
            end
        end
        if (rst_n && ok_cnt[1] > 0 && cyc == ok_cyc[1] + 5) begin
            n_tests++;
            if (utc[1] !== 32'd0 || now[1] !== 32'd0) begin
                n_fail++;
                $display("FAIL sec_wrap: got utc=%h ns=%0d, expected utc=0 ns=0", utc[1], now[1]);
            end
        end
        if (rst_n && ok_cnt[2] > 0 && cyc == ok_cyc[2] + 19) begin
            n_tests++;
            if (locked[2] !== 1'b1 || utc[2] !== last_sec[2] + 32'd1) begin
                n_fail++;
                $display("FAIL hold_edge: got lock=%b utc=%h, expected lock=1 utc=%h", locked[2], utc[2], last_sec[2] + 32'd1);
            end
        end
        if (rst_n && ok_cnt[2] > 0 && cyc == ok_cyc[2] + 20) begin
            n_tests++;
            if (locked[2] !== 1'b0 || utc[2] !== last_sec[2] + 32'd2) begin
                n_fail++;
                $display("FAIL hold_drop: got lock=%b utc=%h, expected lock=0 utc=%h", locked[2], utc[2], last_sec[2] + 32'd2);
            end
        end
    end

    task automatic drive(input int d, input logic v, input int nb);
        rx[d] = v;
        repeat (nb * TB) @(negedge clk);
    endtask

    task automatic send_byte(input int d, input logic [7:0] b, input logic stop);
        drive(d, 1'b0, 1);
        for (int k = 0; k < 8; k++) drive(d, b[k], 1);
        drive(d, stop, 1);
        drive(d, 1'b1, 2);
    endtask

    task automatic send_seq(input int d, input logic [71:0] data, input int n);
        for (int k = n - 1; k >= 0; k--) send_byte(d, data[8*k +: 8], 1'b1);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) rx[i] = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if ({utc[i], now[i], locked[i], fok[i], err[i]} !== 74'd0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: got utc=%h ns=%0d lock=%b ok=%b err=%0d, expected all 0",
                         i, utc[i], now[i], locked[i], fok[i], err[i]);
            end
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (now[i] !== 32'(nspc[i] * 5) || utc[i] !== 32'd0) begin
                n_fail++;
                $display("FAIL free_run_start dut%0d: got ns=%0d utc=%h, expected ns=%0d utc=0", i, now[i], utc[i], nspc[i] * 5);
            end
        end
    endtask

    task automatic test_good_frame();
        int c0 = ok_cnt[0];
        exp_q.push_back('{dut: 2'd0, sec: 32'h1234_5678});
        send_seq(0, 72'hAA_5512_3456_7808, 7);
        n_tests++;
        if (exp_q.size() != 0 || ok_cnt[0] != c0 + 1) begin
            n_fail++;
            $display("FAIL good_frame_seen: got pulses=%0d pending=%0d, expected pulses=1 pending=0", ok_cnt[0] - c0, exp_q.size());
        end
        n_tests++;
        if (now[0] !== 32'(10 * (cyc - ok_cyc[0])) || locked[0] !== 1'b1 || err[0] !== 8'd0) begin
            n_fail++;
            $display("FAIL good_frame_run: got ns=%0d lock=%b err=%0d, expected ns=%0d lock=1 err=0",
                     now[0], locked[0], err[0], 10 * (cyc - ok_cyc[0]));
        end
    endtask

    task automatic test_bad_checksum();
        int c0 = ok_cnt[0];
        send_seq(0, 72'hAA_5512_3456_7809, 7);
        n_tests++;
        if (ok_cnt[0] != c0 || err[0] !== 8'd1 || utc[0] !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL bad_ck: got pulses=%0d err=%0d utc=%h, expected pulses=0 err=1 utc=12345678", ok_cnt[0] - c0, err[0], utc[0]);
        end
        n_tests++;
        if (now[0] !== 32'(10 * (cyc - ok_cyc[0]))) begin
            n_fail++;
            $display("FAIL bad_ck_run: got ns=%0d, expected ns=%0d", now[0], 10 * (cyc - ok_cyc[0]));
        end
    endtask

    task automatic test_wrap();
        longint unsigned tot;
        exp_q.push_back('{dut: 2'd1, sec: 32'hFFFF_FFFF});
        send_seq(1, 72'hAA_55FF_FFFF_FF00, 7);
        tot = 64'd999_999_950 + 64'd10 * 64'(cyc - ok_cyc[1]);
        n_tests++;
        if (exp_q.size() != 0 || utc[1] !== 32'(64'hFFFF_FFFF + tot / 64'd1_000_000_000)
            || now[1] !== 32'(tot % 64'd1_000_000_000)) begin
            n_fail++;
            $display("FAIL wrap_run: got utc=%h ns=%0d pending=%0d, expected utc=%h ns=%0d pending=0", utc[1], now[1],
                     exp_q.size(), 32'(64'hFFFF_FFFF + tot / 64'd1_000_000_000), 32'(tot % 64'd1_000_000_000));
        end
    endtask

    task automatic test_resync();
        int c0;
        exp_q.push_back('{dut: 2'd0, sec: 32'd1});
        send_seq(0, 72'h55_AAAA_5500_0000_0101, 9);
        n_tests++;
        if (exp_q.size() != 0 || err[0] !== 8'd1) begin
            n_fail++;
            $display("FAIL resync: got pending=%0d err=%0d, expected pending=0 err=1", exp_q.size(), err[0]);
        end
        c0 = ok_cnt[0];
        send_byte(0, 8'hAA, 1'b0);
        send_seq(0, 72'h55_0000_0002_02, 6);
        n_tests++;
        if (err[0] !== 8'd2 || ok_cnt[0] != c0) begin
            n_fail++;
            $display("FAIL framing_drop: got err=%0d pulses=%0d, expected err=2 pulses=0", err[0], ok_cnt[0] - c0);
        end
    endtask

    task automatic test_gap_timeout();
        send_seq(0, 72'hAA_5512, 3);
        repeat (250) @(negedge clk);
        n_tests++;
        if (err[0] !== 8'd3) begin
            n_fail++;
            $display("FAIL gap_timeout: got err=%0d, expected err=3", err[0]);
        end
        exp_q.push_back('{dut: 2'd0, sec: 32'd7});
        send_seq(0, 72'hAA_5500_0000_0707, 7);
        n_tests++;
        if (exp_q.size() != 0 || err[0] !== 8'd3 || utc[0] !== 32'd7) begin
            n_fail++;
            $display("FAIL gap_recover: got pending=%0d err=%0d utc=%h, expected pending=0 err=3 utc=7", exp_q.size(), err[0], utc[0]);
        end
    endtask

    task automatic test_holdover_and_reset();
        int c0;
        exp_q.push_back('{dut: 2'd2, sec: 32'h100});
        send_seq(2, 72'hAA_5500_0001_0001, 7);
        repeat (30) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0 || locked[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL holdover: got pending=%0d lock=%b, expected pending=0 lock=0", exp_q.size(), locked[2]);
        end
        send_seq(2, 72'hAA_5512, 3);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({utc[2], now[2], locked[2], fok[2], err[2]} !== 74'd0) begin
            n_fail++;
            $display("FAIL midframe_reset: got utc=%h ns=%0d lock=%b ok=%b err=%0d, expected all 0",
                     utc[2], now[2], locked[2], fok[2], err[2]);
        end
        rst_n = 1'b1;
        c0 = ok_cnt[2];
        send_seq(2, 72'h34_5678_08, 4);
        n_tests++;
        if (ok_cnt[2] != c0 || err[2] !== 8'd0) begin
            n_fail++;
            $display("FAIL partial_discard: got pulses=%0d err=%0d, expected pulses=0 err=0", ok_cnt[2] - c0, err[2]);
        end
        exp_q.push_back('{dut: 2'd2, sec: 32'h0000_ABCD});
        send_seq(2, 72'hAA_5500_00AB_CD66, 7);
        repeat (30) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0 || ok_cnt[2] != c0 + 1) begin
            n_fail++;
            $display("FAIL relock_after_reset: got pulses=%0d pending=%0d, expected pulses=1 pending=0", ok_cnt[2] - c0, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_wrap();
        test_resync();
        test_gap_timeout();
        test_holdover_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
